// File: rtl/button_conditioner_pkg.sv
// Shared types and constant helpers for the stopwatch button conditioner.
// Optional feature macro: BTN_COND_RELEASE_PULSE_EN (adds release pulses).
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Counter width for a given debounce length; never narrower than one bit.
    function automatic int cnt_width(input int debounce_cycles);
        int w;
        w = $clog2(debounce_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM and registered pulses.
// BTN_COND_RELEASE_PULSE_EN adds the rel_pulse output and its register.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press,
`ifdef BTN_COND_RELEASE_PULSE_EN
    output logic rel_pulse,
`endif
    output logic level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q, sync_d;
    logic             s;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             level_q, level_d;
`ifdef BTN_COND_RELEASE_PULSE_EN
    logic             rel_q, rel_d;
`endif

    assign s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], btn};
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
`ifdef BTN_COND_RELEASE_PULSE_EN
        rel_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high returns to PRESSED silently: still the same press.
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef BTN_COND_RELEASE_PULSE_EN
                    rel_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            level_q <= 1'b0;
`ifdef BTN_COND_RELEASE_PULSE_EN
            rel_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            level_q <= level_d;
`ifdef BTN_COND_RELEASE_PULSE_EN
            rel_q   <= rel_d;
`endif
        end
    end

    assign press = press_q;
    assign level = level_q;
`ifdef BTN_COND_RELEASE_PULSE_EN
    assign rel_pulse = rel_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: N_BTN independent debounce channels, wiring only.
// BTN_COND_RELEASE_PULSE_EN adds the releaseOut port.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic [N_BTN-1:0] btnIn,
    output logic [N_BTN-1:0] pressOut,
`ifdef BTN_COND_RELEASE_PULSE_EN
    output logic [N_BTN-1:0] releaseOut,
`endif
    output logic [N_BTN-1:0] levelOut
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clkIn),
            .rst_n     (rstIn),
            .btn       (btnIn[i]),
            .press     (pressOut[i]),
`ifdef BTN_COND_RELEASE_PULSE_EN
            .rel_pulse (releaseOut[i]),
`endif
            .level     (levelOut[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, N_BTN=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_button_conditioner;

    logic       clkIn = 1'b0;
    logic       rstIn;
    logic [2:0] btnIn;
    logic [2:0] pressOut;
    logic [2:0] levelOut;
`ifdef BTN_COND_RELEASE_PULSE_EN
    logic [2:0] releaseOut;
`endif

    int n_cmp = 0;
    int n_err = 0;

    button_conditioner #(
        .N_BTN          (3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .btnIn     (btnIn),
        .pressOut  (pressOut),
`ifdef BTN_COND_RELEASE_PULSE_EN
        .releaseOut(releaseOut),
`endif
        .levelOut  (levelOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; the new input values set before this are captured at this edge.
    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    initial begin
        rstIn = 1'b0;
        btnIn = 3'b000;
        #1;

        // Reset state
        tick();
        check("rst_press", pressOut, 3'b000);
        check("rst_level", levelOut, 3'b000);
        tick();
        rstIn = 1'b1;
        tick();
        check("post_rst_press", pressOut, 3'b000);
        check("post_rst_level", levelOut, 3'b000);
`ifdef BTN_COND_RELEASE_PULSE_EN
        check("post_rst_release", releaseOut, 3'b000);
`endif
        tick();

        // Clean press on channel 0: pulse visible after the 6th edge from capture
        btnIn[0] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("clean_press", pressOut, (t == 6) ? 3'b001 : 3'b000);
            check("clean_level", levelOut, (t >= 6) ? 3'b001 : 3'b000);
        end

        // Bounce on channel 1
        btnIn[1] = 1'b1; tick(); check("bounce_press", pressOut, 3'b000);
        btnIn[1] = 1'b0; tick(); check("bounce_press", pressOut, 3'b000);
        btnIn[1] = 1'b1; tick(); check("bounce_press", pressOut, 3'b000);
        btnIn[1] = 1'b0; tick(); check("bounce_press", pressOut, 3'b000);
        btnIn[1] = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            check("bounce_final_press", pressOut, (t == 6) ? 3'b010 : 3'b000);
            check("bounce_final_level", levelOut, (t >= 6) ? 3'b011 : 3'b001);
        end

        // Short glitch on channel 2: three high captures, never accepted
        btnIn[2] = 1'b1; tick();
        check("glitch_press", pressOut, 3'b000);
        tick();
        check("glitch_press", pressOut, 3'b000);
        tick();
        check("glitch_press", pressOut, 3'b000);
        btnIn[2] = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("glitch_press", pressOut, 3'b000);
            check("glitch_level", levelOut, 3'b011);
        end

        // Clean slate, then simultaneous presses and release
        btnIn = 3'b000;
        rstIn = 1'b0;
        tick();
        check("rst2_level", levelOut, 3'b000);
        rstIn = 1'b1;
        tick();
        btnIn = 3'b111;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("simul_press", pressOut, (t == 6) ? 3'b111 : 3'b000);
            check("simul_level", levelOut, (t >= 6) ? 3'b111 : 3'b000);
        end
        btnIn = 3'b000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("release_press", pressOut, 3'b000);
            check("release_level", levelOut, (t >= 6) ? 3'b000 : 3'b111);
`ifdef BTN_COND_RELEASE_PULSE_EN
            check("release_pulse", releaseOut, (t == 6) ? 3'b111 : 3'b000);
`endif
        end

        // Reset during PRESS_WAIT with the button held through it
        btnIn[0] = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            check("pw_press", pressOut, 3'b000);
        end
        rstIn = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check("midrst_press", pressOut, 3'b000);
            check("midrst_level", levelOut, 3'b000);
        end
        rstIn = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("held_press", pressOut, (t == 6) ? 3'b001 : 3'b000);
            check("held_level", levelOut, (t >= 6) ? 3'b001 : 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
